// File: rtl/fir_filter.sv
// ----------------------------------------------------------------------------
// fir_filter
//    Direct-form FIR filter for a sparse, strobed, signed sample stream.
//    Each accepted sample is shifted into an N_TAPS-deep delay line. One
//    multiplier is shared across all taps, so the filter computes one tap
//    per clock. The result is presented N_TAPS clocks after the strobe.
//
// Ports
//    clk         in   1          rising-edge clock
//    rst_n       in   1          asynchronous active-low reset
//    data        in   DATA_SIZE  signed input sample
//    data_ready  in   1          sample strobe (rising edge is the event)
//    out_data    out  OUT_SIZE   signed filter result, held between results
//    out_valid   out  1          one-cycle pulse when out_data is new
//    busy        out  1          high while a MAC sequence runs
//    overrun     out  1          one-cycle pulse when a strobe was dropped
// ----------------------------------------------------------------------------
module fir_filter #(
   parameter int DATA_SIZE  = 9,
   parameter int N_TAPS     = 3,
   parameter int COEFF_SIZE = 8,
   parameter logic [N_TAPS*COEFF_SIZE-1:0] COEFFS = {8'sd1, 8'sd2, 8'sd1},
   localparam int OUT_SIZE  = DATA_SIZE + COEFF_SIZE + $clog2(N_TAPS + 1)
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic signed [DATA_SIZE-1:0] data,
   input  logic                        data_ready,
   output logic signed [OUT_SIZE-1:0]  out_data,
   output logic                        out_valid,
   output logic                        busy,
   output logic                        overrun
);

   // Width of the tap index; a single-tap filter still needs one bit.
   localparam int TAP_W  = (N_TAPS > 1) ? $clog2(N_TAPS) : 1;
   // Full product width and the sign-extension needed to reach OUT_SIZE.
   localparam int PROD_W = DATA_SIZE + COEFF_SIZE;
   localparam int EXT_W  = OUT_SIZE - PROD_W;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      MAC  = 1'b1
   } state_t;

   state_t                 state_q;
   logic [DATA_SIZE-1:0]   x_q [N_TAPS];
   logic [OUT_SIZE-1:0]    acc_q;
   logic [TAP_W-1:0]       tap_q;
   logic                   rdy_q;
   logic [OUT_SIZE-1:0]    out_data_q;
   logic                   out_valid_q;
   logic                   busy_q;
   logic                   overrun_q;

   logic                   strobe_s;
   logic                   last_tap_s;
   logic [DATA_SIZE-1:0]   sel_x_s;
   logic [COEFF_SIZE-1:0]  sel_h_s;
   logic [PROD_W-1:0]      op_x_s;
   logic [PROD_W-1:0]      op_h_s;
   logic [PROD_W-1:0]      prod_s;
   logic [OUT_SIZE-1:0]    prod_ext_s;
   logic [OUT_SIZE-1:0]    acc_d;

   // Rising edge of data_ready: a held level counts as a single strobe.
   assign strobe_s   = data_ready & ~rdy_q;
   assign last_tap_s = (tap_q == TAP_W'(N_TAPS - 1));

   // Select the delay-line sample and coefficient for the current tap.
   always_comb begin
      sel_x_s = '0;
      sel_h_s = '0;
      for (int i = 0; i < N_TAPS; i++) begin
         sel_x_s = (tap_q == TAP_W'(i)) ? x_q[i] : sel_x_s;
         sel_h_s = (tap_q == TAP_W'(i)) ? COEFFS[i*COEFF_SIZE +: COEFF_SIZE] : sel_h_s;
      end
   end

   // Signed multiply: both operands are sign-extended to the product width,
   // so the low PROD_W bits of the unsigned product are the exact signed
   // result (the true product always fits in PROD_W bits).
   assign op_x_s     = {{COEFF_SIZE{sel_x_s[DATA_SIZE-1]}}, sel_x_s};
   assign op_h_s     = {{DATA_SIZE{sel_h_s[COEFF_SIZE-1]}}, sel_h_s};
   assign prod_s     = op_x_s * op_h_s;
   assign prod_ext_s = {{EXT_W{prod_s[PROD_W-1]}}, prod_s};
   assign acc_d      = acc_q + prod_ext_s;

   // Strobe history, delay line, MAC sequencing and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         for (int i = 0; i < N_TAPS; i++) begin
            x_q[i] <= '0;
         end
         acc_q       <= '0;
         tap_q       <= '0;
         rdy_q       <= 1'b0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         rdy_q       <= data_ready;
         out_valid_q <= 1'b0;
         overrun_q   <= 1'b0;
         case (state_q)
            IDLE: begin
               if (strobe_s) begin
                  x_q[0] <= data;
                  for (int i = 1; i < N_TAPS; i++) begin
                     x_q[i] <= x_q[i-1];
                  end
                  acc_q   <= '0;
                  tap_q   <= '0;
                  busy_q  <= 1'b1;
                  state_q <= MAC;
               end else begin
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
               end
            end
            MAC: begin
               // Any strobe seen here, including on the final tap, is lost.
               overrun_q <= strobe_s;
               acc_q     <= acc_d;
               if (last_tap_s) begin
                  out_data_q  <= acc_d;
                  out_valid_q <= 1'b1;
                  busy_q      <= 1'b0;
                  tap_q       <= '0;
                  state_q     <= IDLE;
               end else begin
                  tap_q   <= tap_q + TAP_W'(1);
                  busy_q  <= 1'b1;
                  state_q <= MAC;
               end
            end
            default: begin
               busy_q  <= 1'b0;
               tap_q   <= '0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign out_data  = out_data_q;
   assign out_valid = out_valid_q;
   assign busy      = busy_q;
   assign overrun   = overrun_q;

endmodule

// File: tb/tb_fir_filter.sv
module tb_fir_filter;

   localparam int DW = 9;
   localparam int OW = 19;

   logic                 clk;
   logic                 rst_n;
   logic signed [DW-1:0] data;
   logic                 data_ready;
   logic signed [OW-1:0] out_data;
   logic                 out_valid;
   logic                 busy;
   logic                 overrun;

   fir_filter dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .data       (data),
      .data_ready (data_ready),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .busy       (busy),
      .overrun    (overrun)
   );

   initial clk = 1'b0;
   always #20 clk = ~clk;

   typedef struct {
      logic signed [DW-1:0] d;
      logic signed [OW-1:0] y;
   } vec_t;

   vec_t tbl [17];

   int n_chk   = 0;
   int n_fail  = 0;
   int n_valid = 0;
   int n_ovr   = 0;
   logic signed [OW-1:0] exp_q [$];
   logic signed [OW-1:0] last_y = '0;

   task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Scoreboard monitor: pops an expected result for each out_valid and
   // checks that out_data holds steady otherwise.
   always @(negedge clk) begin
      if (!rst_n) begin
         last_y = '0;
      end else if (out_valid) begin
         n_valid++;
         if (exp_q.size() == 0) begin
            chk("unexpected_valid", 32'sd1, 32'sd0);
         end else begin
            last_y = exp_q.pop_front();
            chk("out_data", out_data, last_y);
         end
      end else begin
         chk("out_hold", out_data, last_y);
      end
      if (rst_n && overrun) n_ovr++;
   end

   // One strobe, with busy and latency checks, padded to 10 cycles.
   task automatic send(input logic signed [DW-1:0] d, input logic signed [OW-1:0] y);
      @(posedge clk); #5;
      data = d; data_ready = 1'b1;
      exp_q.push_back(y);
      @(posedge clk); #1;
      chk("busy_after_strobe", busy, 1);
      #4 data_ready = 1'b0;
      repeat (2) begin
         @(posedge clk); #1;
         chk("early_valid", out_valid, 0);
      end
      @(posedge clk); #1;
      chk("latency_valid", out_valid, 1);
      chk("busy_done", busy, 0);
      chk("no_overrun", overrun, 0);
      repeat (6) @(posedge clk);
   endtask

   initial begin
      int v0, o0;
      tbl[0]  = '{9'h010, 19'sd16};
      tbl[1]  = '{9'h015, 19'sd53};
      tbl[2]  = '{9'h020, 19'sd90};
      tbl[3]  = '{9'h025, 19'sd122};
      tbl[4]  = '{9'h030, 19'sd154};
      tbl[5]  = '{9'h035, 19'sd186};
      tbl[6]  = '{9'h040, 19'sd218};
      tbl[7]  = '{9'h045, 19'sd250};
      tbl[8]  = '{9'h050, 19'sd282};
      tbl[9]  = '{9'h055, 19'sd314};
      tbl[10] = '{9'h060, 19'sd346};
      tbl[11] = '{9'h065, 19'sd378};
      tbl[12] = '{9'h000, 19'sd298};
      tbl[13] = '{9'h000, 19'sd101};
      tbl[14] = '{9'h153, -19'sd173};
      tbl[15] = '{9'h000, -19'sd346};
      tbl[16] = '{9'h000, -19'sd173};

      rst_n = 1'b0; data = '0; data_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_out_data", out_data, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_overrun", overrun, 0);
      #4 rst_n = 1'b1;
      repeat (2) @(posedge clk);

      // Streams of samples including sign handling
      for (int i = 0; i < 17; i++) begin
         send(tbl[i].d, tbl[i].y);
      end
      chk("stream_overruns", n_ovr, 0);
      chk("stream_valids", n_valid, 17);

      // Level held 5 cycles: one sample only (history 0,0 -> 16)
      v0 = n_valid; o0 = n_ovr;
      @(posedge clk); #5;
      data = 9'h010; data_ready = 1'b1;
      exp_q.push_back(19'sd16);
      repeat (5) @(posedge clk);
      #5 data_ready = 1'b0;
      repeat (10) @(posedge clk);
      chk("hold_valids", n_valid - v0, 1);
      chk("hold_overruns", n_ovr - o0, 0);

      // Second strobe 2 cycles after first: dropped, overrun pulse
      v0 = n_valid; o0 = n_ovr;
      @(posedge clk); #5;
      data = 9'h020; data_ready = 1'b1;
      exp_q.push_back(19'sd64);        // 32 + 2*16 + 0
      @(posedge clk); #5 data_ready = 1'b0;
      @(posedge clk); #5;
      data = 9'h07F; data_ready = 1'b1;
      @(posedge clk); #5 data_ready = 1'b0;
      repeat (10) @(posedge clk);
      chk("ovr_valids", n_valid - v0, 1);
      chk("ovr_pulses", n_ovr - o0, 1);

      // Reset during MAC: abort, no out_valid, everything cleared
      v0 = n_valid;
      @(posedge clk); #5;
      data = 9'h030; data_ready = 1'b1;
      @(posedge clk); #5 data_ready = 1'b0;
      @(posedge clk); #5 rst_n = 1'b0;
      #1;
      chk("abort_out_data", out_data, 0);
      chk("abort_busy", busy, 0);
      chk("abort_valid", out_valid, 0);
      @(posedge clk); #5 rst_n = 1'b1;
      repeat (10) @(posedge clk);
      chk("abort_no_valid", n_valid - v0, 0);
      send(9'h010, 19'sd16);

      chk("queue_empty", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
